// File: rtl/demux16b1_2_buf.sv
// 1-to-2 demultiplexer: one valid/ready input stream steered by S
// into two independent FIFO lanes, each drained by its own consumer.
module demux16b1_2_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic [WIDTH-1:0]           I,
    input  logic                       S,
    input  logic                       in_vld,
    output logic                       in_rdy,
    output logic [WIDTH-1:0]           O0,
    output logic                       V0,
    input  logic                       R0,
    output logic [WIDTH-1:0]           O1,
    output logic                       V1,
    input  logic                       R1,
    output logic [$clog2(DEPTH+1)-1:0] cnt0,
    output logic [$clog2(DEPTH+1)-1:0] cnt1
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [2][DEPTH];
    logic [AW-1:0]    wp_q  [2];
    logic [AW-1:0]    wp_d  [2];
    logic [AW-1:0]    rp_q  [2];
    logic [AW-1:0]    rp_d  [2];
    logic [CW-1:0]    cnt_q [2];
    logic [CW-1:0]    cnt_d [2];

    logic [1:0] full;
    logic [1:0] vld;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] rdy_lane;

    // Push acceptance never looks at the consumer readies.
    always_comb begin
        full[0]  = (cnt_q[0] == FULL_CNT);
        full[1]  = (cnt_q[1] == FULL_CNT);
        vld[0]   = (cnt_q[0] != '0);
        vld[1]   = (cnt_q[1] != '0);
        rdy_lane = {R1, R0};
        in_rdy   = S ? !full[1] : !full[0];
        push[0]  = in_vld && in_rdy && !S;
        push[1]  = in_vld && in_rdy && S;
        pop      = vld & rdy_lane;
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            wp_d[k]  = wp_q[k] + AW'(push[k]);
            rp_d[k]  = rp_q[k] + AW'(pop[k]);
            cnt_d[k] = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < 2; k++) begin
                wp_q[k]  <= '0;
                rp_q[k]  <= '0;
                cnt_q[k] <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[k][e] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                wp_q[k]  <= wp_d[k];
                rp_q[k]  <= rp_d[k];
                cnt_q[k] <= cnt_d[k];
                if (push[k]) begin
                    mem_q[k][wp_q[k]] <= I;
                end
            end
        end
    end

    // Heads are forced to zero while a lane is empty.
    assign V0   = vld[0];
    assign V1   = vld[1];
    assign O0   = vld[0] ? mem_q[0][rp_q[0]] : '0;
    assign O1   = vld[1] ? mem_q[1][rp_q[1]] : '0;
    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];

endmodule
